// File: rtl/beep_pulse_gen_pkg.sv
// beep_pulse_gen_pkg: shared state encoding, queue width and default timing for the beep generator.
package beep_pulse_gen_pkg;
    typedef enum logic [1:0] {IDLE, ON, GAP} state_t;
    localparam int PEND_W         = 4;
    localparam int DEF_CW         = 20;
    localparam int DEF_ON_CYCLES  = 1000000;
    localparam int DEF_GAP_CYCLES = 500000;
    localparam int DEF_TONE_HALF  = 25000;
    localparam int DEF_MAX_PEND   = 3;
endpackage

// File: rtl/beep_pulse_gen_tone_div.sv
// beep_pulse_gen_tone_div: half-period divider with synchronous phase restart; output registered and gated.
module beep_pulse_gen_tone_div #(
    parameter int CW   = 20,
    parameter int HALF = 25000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart_i,
    input  logic en_i,
    input  logic gate_i,
    output logic tone_o
);
    logic [CW-1:0] cnt_q, cnt_d;
    logic phase_q, phase_d, tone_q, wrap;
    assign wrap = cnt_q == CW'(HALF - 1);
    always_comb begin
        cnt_d   = restart_i ? '0 : en_i ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
        phase_d = restart_i ? 1'b1 : (en_i && wrap) ? ~phase_q : phase_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            tone_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            tone_q  <= gate_i & phase_d;
        end
    end
    assign tone_o = tone_q;
endmodule

// File: rtl/beep_pulse_gen.sv
// beep_pulse_gen: turns one-cycle trig pulses into timed beeps with a gated tone.
// Request queueing is enabled by defining BEEP_PEND_QUEUE_EN.
module beep_pulse_gen
    import beep_pulse_gen_pkg::*;
#(
    parameter int CW         = DEF_CW,
    parameter int ON_CYCLES  = DEF_ON_CYCLES,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int TONE_HALF  = DEF_TONE_HALF,
    parameter int MAX_PEND   = DEF_MAX_PEND
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trig,
    output logic              out_level,
    output logic              tone,
    output logic              busy,
    output logic [PEND_W-1:0] pend_count,
    output logic              drop
);
`ifdef BEEP_PEND_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic out_q, busy_q, drop_q;
    logic on_end, gap_end, accept, consume;
    assign on_end  = state_q == ON && cnt_q == CW'(ON_CYCLES - 1);
    assign gap_end = state_q == GAP && cnt_q == CW'(GAP_CYCLES - 1);
    // A full queue still accepts on the GAP terminal count, since one entry is consumed there.
    assign accept  = QEN && trig && state_q != IDLE && (pend_q < PEND_W'(MAX_PEND) || gap_end);
    assign consume = QEN && gap_end && (pend_q != '0 || accept);
    always_comb begin
        state_d = state_q == IDLE ? (trig ? ON : IDLE) :
                  on_end ? GAP : gap_end ? (consume ? ON : IDLE) : state_q;
        cnt_d   = (state_q == IDLE || on_end || gap_end) ? '0 : cnt_q + 1'b1;
        pend_d  = pend_q + PEND_W'(accept) - PEND_W'(consume);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            out_q   <= state_d == ON;
            busy_q  <= state_d != IDLE;
            drop_q  <= trig && state_q != IDLE && !accept;
        end
    end
    beep_pulse_gen_tone_div #(.CW(CW), .HALF(TONE_HALF)) u_tone (
        .clk      (clk),
        .reset    (reset),
        .restart_i(state_q != ON && state_d == ON),
        .en_i     (state_q == ON),
        .gate_i   (state_d == ON),
        .tone_o   (tone)
    );
    assign out_level  = out_q;
    assign busy       = busy_q;
    assign pend_count = pend_q;
    assign drop       = drop_q;
endmodule

// File: tb/tb_beep_pulse_gen.sv
// tb_beep_pulse_gen: directed scenarios plus randomized trig traffic against a period-position model.
module tb_beep_pulse_gen;
    localparam int ON   = 4;
    localparam int GAP  = 2;
    localparam int TH   = 1;
    localparam int MAXP = 2;
`ifdef BEEP_PEND_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1, trig = 1'b0;
    logic out_level, tone, busy, drop;
    logic [3:0] pend_count;
    int errors = 0, checks = 0;
    int m_pos = -1, m_pend = 0;
    bit m_drop = 1'b0;

    beep_pulse_gen #(.CW(20), .ON_CYCLES(ON), .GAP_CYCLES(GAP), .TONE_HALF(TH), .MAX_PEND(MAXP)) dut (
        .clk(clk), .reset(reset), .trig(trig), .out_level(out_level), .tone(tone),
        .busy(busy), .pend_count(pend_count), .drop(drop)
    );

    always #5 clk = ~clk;

    // Model: position within the ON+GAP period (-1 when idle) and a count of waiting requests.
    function automatic void model_step(input bit t, input bit r);
        bit last;
        m_drop = 1'b0;
        if (r) begin
            m_pos = -1;
            m_pend = 0;
        end else if (m_pos < 0) begin
            if (t) m_pos = 0;
        end else begin
            last = m_pos == ON + GAP - 1;
            if (t) begin
                if (QEN && (m_pend < MAXP || (last && m_pend > 0))) m_pend++;
                else if (QEN && last) m_pend++;
                else m_drop = 1'b1;
            end
            if (last) begin
                if (m_pend > 0) begin
                    m_pend--;
                    m_pos = 0;
                end else m_pos = -1;
            end else m_pos++;
        end
    endfunction

    function automatic bit m_out();
        return m_pos >= 0 && m_pos < ON;
    endfunction

    function automatic bit m_tone();
        return m_out() && ((m_pos / TH) % 2 == 0);
    endfunction

    task automatic tick(input bit t, input bit r);
        trig = t;
        reset = r;
        @(posedge clk);
        model_step(t, r);
        #1;
        trig = 1'b0;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    task automatic test_reset;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        checks++; if (out_level !== 1'b0) begin errors++; $display("FAIL reset_out got=%b exp=0", out_level); end
        checks++; if (tone !== 1'b0) begin errors++; $display("FAIL reset_tone got=%b exp=0", tone); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (pend_count !== 4'd0) begin errors++; $display("FAIL reset_pend got=%0d exp=0", pend_count); end
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", drop); end
        idle(8);
    endtask

    task automatic test_single;
        logic [7:0] o, b, tn;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            o[i] = out_level;
            b[i] = busy;
            tn[i] = tone;
            tick(1'b0, 1'b0);
        end
        checks++; if (o !== 8'b0000_1111) begin errors++; $display("FAIL single_out got=%b exp=%b", o, 8'b0000_1111); end
        checks++; if (b !== 8'b0011_1111) begin errors++; $display("FAIL single_busy got=%b exp=%b", b, 8'b0011_1111); end
        checks++; if (tn !== 8'b0000_0101) begin errors++; $display("FAIL single_tone got=%b exp=%b", tn, 8'b0000_0101); end
        idle(4);
    endtask

    task automatic test_queue;
        int highs = 0;
        tick(1'b1, 1'b0);
        highs += int'(out_level);
        tick(1'b0, 1'b0);
        highs += int'(out_level);
        tick(1'b1, 1'b0);
        highs += int'(out_level);
        checks++; if (pend_count !== 4'(QEN)) begin errors++; $display("FAIL queue_pend got=%0d exp=%0d", pend_count, QEN); end
        checks++; if (drop !== !QEN) begin errors++; $display("FAIL queue_drop got=%b exp=%b", drop, !QEN); end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0);
            highs += int'(out_level);
        end
        checks++; if (out_level !== QEN) begin errors++; $display("FAIL queue_second_start got=%b exp=%b", out_level, QEN); end
        checks++; if (pend_count !== 4'd0) begin errors++; $display("FAIL queue_pend_after got=%0d exp=0", pend_count); end
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 1'b0);
            highs += int'(out_level);
        end
        checks++; if (highs != (QEN ? 2 * ON : ON)) begin errors++; $display("FAIL queue_high_cycles got=%0d exp=%0d", highs, QEN ? 2 * ON : ON); end
    endtask

    task automatic test_saturate;
        int beeps = 0, drops = 0, maxp = 0;
        logic prev = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(i < 4, 1'b0);
            beeps += int'(out_level && !prev);
            drops += int'(drop);
            maxp = int'(pend_count) > maxp ? int'(pend_count) : maxp;
            prev = out_level;
        end
        checks++; if (beeps != (QEN ? 3 : 1)) begin errors++; $display("FAIL sat_beeps got=%0d exp=%0d", beeps, QEN ? 3 : 1); end
        checks++; if (drops != (QEN ? 1 : 3)) begin errors++; $display("FAIL sat_drops got=%0d exp=%0d", drops, QEN ? 1 : 3); end
        checks++; if (maxp != (QEN ? MAXP : 0)) begin errors++; $display("FAIL sat_max_pend got=%0d exp=%0d", maxp, QEN ? MAXP : 0); end
    endtask

    task automatic test_gap_trig;
        tick(1'b1, 1'b0);
        idle(ON + GAP - 1);
        checks++; if (busy !== 1'b1 || out_level !== 1'b0) begin errors++; $display("FAIL gap_last_state busy=%b out=%b exp busy=1 out=0", busy, out_level); end
        tick(1'b1, 1'b0);
        checks++; if (out_level !== QEN) begin errors++; $display("FAIL gap_trig_out got=%b exp=%b", out_level, QEN); end
        checks++; if (busy !== QEN) begin errors++; $display("FAIL gap_trig_busy got=%b exp=%b", busy, QEN); end
        checks++; if (pend_count !== 4'd0) begin errors++; $display("FAIL gap_trig_pend got=%0d exp=0", pend_count); end
        checks++; if (drop !== !QEN) begin errors++; $display("FAIL gap_trig_drop got=%b exp=%b", drop, !QEN); end
        idle(12);
    endtask

    task automatic test_reset_mid;
        int highs = 0;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        checks++; if (pend_count !== 4'(QEN) || out_level !== 1'b1) begin errors++; $display("FAIL mid_pre pend=%0d out=%b exp pend=%0d out=1", pend_count, out_level, QEN); end
        tick(1'b0, 1'b1);
        checks++; if ({out_level, tone, busy, drop, pend_count} !== 8'd0) begin errors++; $display("FAIL mid_reset_outputs got=%b exp=0", {out_level, tone, busy, drop, pend_count}); end
        for (int i = 0; i < 15; i++) begin
            tick(1'b0, 1'b0);
            highs += int'(out_level) + int'(busy);
        end
        checks++; if (highs != 0) begin errors++; $display("FAIL mid_no_beep got=%0d exp=0", highs); end
    endtask

    task automatic test_random;
        int bad = 0;
        for (int i = 0; i < 1500; i++) begin
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
            checks++; if (out_level !== m_out()) begin errors++; bad++; if (bad < 10) $display("FAIL rnd_out cyc=%0d got=%b exp=%b", i, out_level, m_out()); end
            checks++; if (tone !== m_tone()) begin errors++; bad++; if (bad < 10) $display("FAIL rnd_tone cyc=%0d got=%b exp=%b", i, tone, m_tone()); end
            checks++; if (busy !== (m_pos >= 0)) begin errors++; bad++; if (bad < 10) $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, busy, m_pos >= 0); end
            checks++; if (pend_count !== 4'(m_pend)) begin errors++; bad++; if (bad < 10) $display("FAIL rnd_pend cyc=%0d got=%0d exp=%0d", i, pend_count, m_pend); end
            checks++; if (drop !== m_drop) begin errors++; bad++; if (bad < 10) $display("FAIL rnd_drop cyc=%0d got=%b exp=%b", i, drop, m_drop); end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_queue;
        test_saturate;
        test_gap_trig;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
